pipeline_hazard_controller: RTL and testbench

//  Sequences the 5-stage RISC-V pipeline: per-cycle pc/IF-ID/ID-EX/EX-MEM/MEM-WB write/flush enables

---
 rtl/pipeline_hazard_controller_pkg.sv | 15 +
 rtl/pipeline_hazard_controller_if.sv | 42 ++++
 rtl/pipeline_hazard_controller_hazard_detect.sv | 32 +++
 rtl/pipeline_hazard_controller.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - shared state encoding and ecall register constants
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    // a7 (x17) carries the ecall code; code 10 requests a halt
    localparam int HALT_REG  = 17;
    localparam int HALT_CODE = 10;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - decoded pipeline control in, stage enables and counters out
interface pipeline_hazard_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  id_is_ecall;
    logic                  id_halt_req;
    logic                  ex_mem_read;
    logic                  ex_write_en;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_redirect;
    logic                  dmem_ready;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_write;
    logic                  mem_wb_flush;
    logic                  is_halted;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall, id_halt_req,
               ex_mem_read, ex_write_en, ex_rd, ex_redirect, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
               mem_wb_flush, is_halted, stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_ecall, id_halt_req,
               ex_mem_read, ex_write_en, ex_rd, ex_redirect, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
               mem_wb_flush, is_halted, stall_count, flush_count
    );

endinterface

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// rtl/pipeline_hazard_controller_hazard_detect.sv - load-use and ecall-x17 register dependency compare
module pipeline_hazard_controller_hazard_detect
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_is_ecall,
    input  logic                  ex_mem_read,
    input  logic                  ex_write_en,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use,
    output logic                  ecall_stall
);
    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // writes to x0 are discarded, so they can never create a dependency
    assign rd_live = (ex_rd != '0);
    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

    assign load_use = ex_mem_read && rd_live && (rs1_hit || rs2_hit);

    // ecall reads a7 from the register file only, so an in-flight write must land first
    assign ecall_stall = id_is_ecall && ex_write_en && (ex_rd == REG_ADDR_W'(HALT_REG));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - 5-stage pipeline sequencing FSM, stall/flush enables and counters
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    pipeline_hazard_controller_if.slave bus
);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_next;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    logic               stall_hit;
    logic               flush_hit;
    logic               load_use;
    logic               ecall_stall;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
    logic is_halted;

    pipeline_hazard_controller_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_use_rs1  (bus.id_use_rs1),
        .id_use_rs2  (bus.id_use_rs2),
        .id_is_ecall (bus.id_is_ecall),
        .ex_mem_read (bus.ex_mem_read),
        .ex_write_en (bus.ex_write_en),
        .ex_rd       (bus.ex_rd),
        .load_use    (load_use),
        .ecall_stall (ecall_stall)
    );

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        is_halted    = 1'b0;
        state_next   = state;
        drain_next   = drain_cnt;
        stall_hit    = 1'b0;
        flush_hit    = 1'b0;

        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if (!bus.dmem_ready) begin
                    // a pending redirect stays in EX and is taken once memory completes
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_flush = 1'b1;
                    stall_hit    = 1'b1;
                    state_next   = ST_MEM_WAIT;
                end else begin
                    state_next = ST_RUN;
                    if (bus.ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_hit   = 1'b1;
                    end else if (load_use || ecall_stall) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_hit   = 1'b1;
                    end else if (bus.id_halt_req) begin
                        pc_write    = 1'b0;
                        if_id_flush = 1'b1;
                        stall_hit   = 1'b1;
                        state_next  = ST_DRAIN;
                        drain_next  = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (!bus.dmem_ready) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_flush = 1'b1;
                end else begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (drain_cnt == '0) begin
                        state_next = ST_HALTED;
                    end else begin
                        drain_next = drain_cnt - 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                ex_mem_write = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                mem_wb_flush = 1'b1;
                is_halted    = 1'b1;
            end
            default: state_next = ST_RUN;
        endcase

        // while reset is held every stage is bubbled and nothing advances
        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
            is_halted    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            if (stall_hit && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_hit && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_write = ex_mem_write;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.is_halted    = is_halted;
    assign bus.stall_count  = stall_cnt;
    assign bus.flush_count  = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed and randomized bench with a behavioural pipeline model
module tb_pipeline_hazard_controller;
    localparam int RW   = 5;
    localparam int DC   = 3;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    // output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_flush, is_halted}
    localparam logic [6:0] V_RESET  = 7'b0011010;
    localparam logic [6:0] V_HALTED = 7'b0011011;
    localparam logic [6:0] V_FREEZE = 7'b0000010;
    localparam logic [6:0] V_DRAIN  = 7'b0111100;
    localparam logic [6:0] V_REDIR  = 7'b1111100;
    localparam logic [6:0] V_STALL  = 7'b0001100;
    localparam logic [6:0] V_ACCEPT = 7'b0110100;
    localparam logic [6:0] V_RUN    = 7'b1100100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    pipeline_hazard_controller #(
        .REG_ADDR_W   (RW),
        .DRAIN_CYCLES (DC),
        .CNT_W        (CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int nchk = 0;
    int nerr = 0;

    // model: drain_left counts remaining retire cycles, 0 when not draining
    bit m_halted, n_halted;
    int m_drain, n_drain;
    int m_stall, n_stall;
    int m_flush, n_flush;

    function automatic logic [6:0] outs();
        return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
                bus.ex_mem_write, bus.mem_wb_flush, bus.is_halted};
    endfunction

    task automatic model_clear();
        m_halted = 1'b0; m_drain = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval(output logic [6:0] e);
        bit dep;
        n_halted = m_halted; n_drain = m_drain; n_stall = m_stall; n_flush = m_flush;
        dep = (bus.ex_mem_read && bus.ex_rd != 0 &&
               ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd)))
           || (bus.id_is_ecall && bus.ex_write_en && bus.ex_rd == 17);
        if (!reset_n) e = V_RESET;
        else if (m_halted) e = V_HALTED;
        else if (!bus.dmem_ready) begin
            e = V_FREEZE;
            if (m_drain == 0) n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end else if (m_drain > 0) begin
            e = V_DRAIN;
            n_drain = m_drain - 1;
            if (n_drain == 0) n_halted = 1'b1;
        end else if (bus.ex_redirect) begin
            e = V_REDIR;
            n_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        end else if (dep) begin
            e = V_STALL;
            n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end else if (bus.id_halt_req) begin
            e = V_ACCEPT;
            n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            n_drain = DC;
        end else e = V_RUN;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
        if (!reset_n) model_clear();
        else begin
            m_halted = n_halted; m_drain = n_drain; m_stall = n_stall; m_flush = n_flush;
        end
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.id_is_ecall = 1'b0; bus.id_halt_req = 1'b0; bus.ex_mem_read = 1'b0;
        bus.ex_write_en = 1'b0; bus.ex_rd = '0; bus.ex_redirect = 1'b0; bus.dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_clear();
        idle();
        #1;
        if (outs() !== V_RESET) begin nerr++; $display("FAIL reset_outs got=%b exp=%b", outs(), V_RESET); end
        nchk++;
        if (bus.stall_count !== 8'd0 || bus.flush_count !== 8'd0) begin
            nerr++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.stall_count, bus.flush_count);
        end
        nchk++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_load_use();
        logic [6:0] e;
        do_reset();
        idle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.ex_write_en = 1'b1;
        bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd1; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
        #1;
        model_eval(e);
        if (outs() !== V_STALL) begin nerr++; $display("FAIL load_use_outs got=%b exp=%b", outs(), V_STALL); end
        nchk++;
        clock_edge();
        if (bus.stall_count !== 8'd1) begin nerr++; $display("FAIL load_use_stall got=%0d exp=1", bus.stall_count); end
        nchk++;
        idle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
        #1;
        model_eval(e);
        if (outs() !== V_RUN) begin nerr++; $display("FAIL x0_no_stall got=%b exp=%b", outs(), V_RUN); end
        nchk++;
        clock_edge();
        if (bus.stall_count !== 8'd1) begin nerr++; $display("FAIL x0_stall_count got=%0d exp=1", bus.stall_count); end
        nchk++;
    endtask

    task automatic test_redirect();
        logic [6:0] e;
        do_reset();
        idle();
        bus.ex_redirect = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7;
        bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1; bus.id_is_ecall = 1'b1; bus.id_halt_req = 1'b1;
        #1;
        model_eval(e);
        if (outs() !== V_REDIR) begin nerr++; $display("FAIL redirect_outs got=%b exp=%b", outs(), V_REDIR); end
        nchk++;
        clock_edge();
        if (bus.flush_count !== 8'd1 || bus.stall_count !== 8'd0) begin
            nerr++; $display("FAIL redirect_counts got=%0d/%0d exp=1/0", bus.flush_count, bus.stall_count);
        end
        nchk++;
    endtask

    task automatic test_mem_wait();
        logic [6:0] e;
        do_reset();
        idle();
        bus.ex_redirect = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.dmem_ready = (c == 4);
            #1;
            model_eval(e);
            if (outs() !== ((c < 4) ? V_FREEZE : V_REDIR)) begin
                nerr++; $display("FAIL mem_wait_outs cyc=%0d got=%b exp=%b", c, outs(), (c < 4) ? V_FREEZE : V_REDIR);
            end
            nchk++;
            clock_edge();
        end
        if (bus.stall_count !== 8'd4 || bus.flush_count !== 8'd1) begin
            nerr++; $display("FAIL mem_wait_counts got=%0d/%0d exp=4/1", bus.stall_count, bus.flush_count);
        end
        nchk++;
    endtask

    task automatic test_ecall_halt();
        logic [6:0] e;
        int k;
        do_reset();
        idle();
        bus.ex_write_en = 1'b1; bus.ex_rd = 5'd17; bus.id_is_ecall = 1'b1;
        #1;
        model_eval(e);
        if (outs() !== V_STALL) begin nerr++; $display("FAIL ecall_x17_outs got=%b exp=%b", outs(), V_STALL); end
        nchk++;
        clock_edge();
        idle();
        bus.id_is_ecall = 1'b1; bus.id_halt_req = 1'b1;
        #1;
        model_eval(e);
        if (outs() !== V_ACCEPT) begin nerr++; $display("FAIL halt_accept_outs got=%b exp=%b", outs(), V_ACCEPT); end
        nchk++;
        clock_edge();
        idle();
        bus.ex_redirect = 1'b1;
        k = 0;
        while (bus.is_halted !== 1'b1 && k < 10) begin
            #1;
            model_eval(e);
            if (outs() !== e) begin nerr++; $display("FAIL drain_outs cyc=%0d got=%b exp=%b", k, outs(), e); end
            nchk++;
            clock_edge();
            k++;
        end
        if (k !== DC) begin nerr++; $display("FAIL drain_length got=%0d exp=%0d", k, DC); end
        nchk++;
        for (int c = 0; c < 4; c++) begin
            bus.dmem_ready = 1'(c % 2); bus.id_halt_req = 1'b0; bus.ex_redirect = 1'(c == 1);
            #1;
            model_eval(e);
            if (outs() !== V_HALTED) begin nerr++; $display("FAIL halted_sticky cyc=%0d got=%b exp=%b", c, outs(), V_HALTED); end
            nchk++;
            clock_edge();
        end
        if (bus.stall_count !== 8'd2 || bus.flush_count !== 8'd0) begin
            nerr++; $display("FAIL halt_counts got=%0d/%0d exp=2/0", bus.stall_count, bus.flush_count);
        end
        nchk++;
    endtask

    task automatic test_reset_mid_drain();
        logic [6:0] e;
        do_reset();
        idle();
        bus.id_is_ecall = 1'b1; bus.id_halt_req = 1'b1;
        #1;
        model_eval(e);
        clock_edge();
        idle();
        #1;
        model_eval(e);
        if (outs() !== V_DRAIN) begin nerr++; $display("FAIL mid_drain_outs got=%b exp=%b", outs(), V_DRAIN); end
        nchk++;
        clock_edge();
        reset_n = 1'b0;
        model_clear();
        #1;
        if (outs() !== V_RESET || bus.stall_count !== 8'd0 || bus.flush_count !== 8'd0) begin
            nerr++; $display("FAIL async_reset got=%b/%0d/%0d exp=%b/0/0", outs(), bus.stall_count, bus.flush_count, V_RESET);
        end
        nchk++;
        #2;
        reset_n = 1'b1;
        #1;
        model_eval(e);
        if (outs() !== V_RUN) begin nerr++; $display("FAIL after_reset_run got=%b exp=%b", outs(), V_RUN); end
        nchk++;
        clock_edge();
    endtask

    task automatic test_saturation();
        logic [6:0] e;
        do_reset();
        idle();
        bus.dmem_ready = 1'b0;
        for (int c = 0; c < 260; c++) begin
            #1;
            model_eval(e);
            if (outs() !== V_FREEZE) begin nerr++; $display("FAIL sat_outs cyc=%0d got=%b exp=%b", c, outs(), V_FREEZE); end
            nchk++;
            clock_edge();
        end
        if (bus.stall_count !== 8'hFF) begin nerr++; $display("FAIL stall_saturate got=%0d exp=255", bus.stall_count); end
        nchk++;
        idle();
        clock_edge();
    endtask

    task automatic test_random();
        logic [6:0] e;
        do_reset();
        for (int i = 0; i < 640; i++) begin
            if (i % 80 == 0) do_reset();
            bus.id_rs1      = 5'($urandom_range(0, 3));
            bus.id_rs2      = 5'($urandom_range(0, 3));
            bus.id_use_rs1  = 1'($urandom_range(0, 1));
            bus.id_use_rs2  = 1'($urandom_range(0, 1));
            bus.id_halt_req = ($urandom_range(0, 14) == 0);
            bus.id_is_ecall = bus.id_halt_req | ($urandom_range(0, 7) == 0);
            bus.ex_mem_read = ($urandom_range(0, 2) == 0);
            bus.ex_write_en = 1'($urandom_range(0, 1));
            bus.ex_rd       = ($urandom_range(0, 4) == 0) ? 5'd17 : 5'($urandom_range(0, 3));
            bus.ex_redirect = ($urandom_range(0, 5) == 0);
            bus.dmem_ready  = ($urandom_range(0, 4) != 0);
            #1;
            model_eval(e);
            if (outs() !== e) begin nerr++; $display("FAIL rnd_outs cyc=%0d got=%b exp=%b", i, outs(), e); end
            nchk++;
            clock_edge();
            if (bus.stall_count !== CW'(m_stall) || bus.flush_count !== CW'(m_flush)) begin
                nerr++;
                $display("FAIL rnd_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bus.stall_count, bus.flush_count, m_stall, m_flush);
            end
            nchk++;
        end
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_ecall_halt();
        test_reset_mid_drain();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
